// File: rtl/rr_arbiter16.sv
// rr_arbiter16: round-robin arbiter for 16 requesters with hold-timer preemption and one-hot grant decode
module rr_arbiter16 #(
  parameter int MAXHOLD = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        En,
  input  logic [15:0] R,
  output logic [15:0] G,
  output logic [3:0]  gidx,
  output logic        valid,
  output logic        timeout
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      r_state, w_state_n;
  logic [3:0]  r_ptr, w_ptr_n, r_gidx, w_gidx_n, w_win;
  logic [7:0]  r_hold, w_hold_n;
  logic [15:0] r_g, w_g_n, w_cand;
  logic        r_to, w_to_n, w_found, w_rel, w_tmo, w_search, w_grab;
  always_comb begin
    w_rel     = (r_state == BUSY) && !R[r_gidx];
    w_tmo     = (r_state == BUSY) && (MAXHOLD != 0) && (r_hold == 8'(MAXHOLD - 1)) && R[r_gidx];
    // the outgoing owner is masked so a preempted requester cannot immediately win again
    w_cand    = (r_state == BUSY) ? (R & ~(16'd1 << r_gidx)) : R;
    w_found   = 1'b0;
    w_win     = r_ptr;
    for (int k = 15; k >= 0; k--)
      if (w_cand[r_ptr + 4'(k)]) begin
        w_found = 1'b1;
        w_win   = r_ptr + 4'(k);
      end
    w_search  = (r_state == IDLE) || w_rel || w_tmo;
    w_grab    = w_search && En && w_found;
    w_state_n = w_grab ? BUSY : (w_search ? IDLE : r_state);
    w_gidx_n  = w_grab ? w_win : (w_search ? 4'd0 : r_gidx);
    w_ptr_n   = w_grab ? w_win + 4'd1 : r_ptr;
    w_hold_n  = w_search ? 8'd0 : r_hold + {7'd0, r_hold != 8'hFF};
    w_to_n    = w_tmo;
    w_g_n     = (w_state_n == BUSY) ? (16'd1 << w_gidx_n) : 16'd0;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= IDLE;
      r_ptr   <= 4'd0;
      r_gidx  <= 4'd0;
      r_hold  <= 8'd0;
      r_to    <= 1'b0;
      r_g     <= 16'd0;
    end else begin
      r_state <= w_state_n;
      r_ptr   <= w_ptr_n;
      r_gidx  <= w_gidx_n;
      r_hold  <= w_hold_n;
      r_to    <= w_to_n;
      r_g     <= w_g_n;
    end
  end
  assign G       = r_g;
  assign gidx    = r_gidx;
  assign valid   = (r_state == BUSY);
  assign timeout = r_to;
endmodule
